fifo_param_sync: RTL and testbench

//  Parametrised single-clock FIFO: successor to the fixed 16x8 FIFO.

---
 rtl/fifo_param_sync.sv | 137 +++++++++++++
 tb/tb_fifo_param_sync.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/fifo_param_sync.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : fifo_param_sync                                            |
// | Description : Parametrised single-clock FIFO with occupancy count,       |
// |               almost-full / almost-empty thresholds and registered       |
// |               write-ack / overflow / underflow pulses.                   |
// |               Define FIFO_FWFT_EN for first-word fall-through reads;     |
// |               the default build uses registered (1-cycle latency) reads. |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module fifo_param_sync #(
   parameter int FIFO_WIDTH = 16,
   parameter int FIFO_DEPTH = 8,
   parameter int AF_TH      = FIFO_DEPTH - 1,
   parameter int AE_TH      = 1
) (
   input  logic                                clk,
   input  logic                                rst_n,
   input  logic [FIFO_WIDTH-1:0]               data_in,
   input  logic                                wr_en,
   input  logic                                rd_en,
   output logic [FIFO_WIDTH-1:0]               data_out,
   output logic                                wr_ack,
   output logic                                overflow,
   output logic                                underflow,
   output logic                                full,
   output logic                                empty,
   output logic                                almostfull,
   output logic                                almostempty,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]     count
);

   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam int PW = $clog2(FIFO_DEPTH);

   localparam logic [CW-1:0] c_depth    = CW'(FIFO_DEPTH);
   localparam logic [CW-1:0] c_af_th    = CW'(AF_TH);
   localparam logic [CW-1:0] c_ae_th    = CW'(AE_TH);
   localparam logic [CW-1:0] c_cnt_one  = CW'(1);
   localparam logic [PW-1:0] c_ptr_last = PW'(FIFO_DEPTH - 1);
   localparam logic [PW-1:0] c_ptr_one  = PW'(1);

   logic [FIFO_WIDTH-1:0] r_mem [0:FIFO_DEPTH-1];
   logic [PW-1:0]         r_wr_ptr;
   logic [PW-1:0]         r_rd_ptr;
   logic [CW-1:0]         r_count;
   logic                  r_wr_ack;
   logic                  r_overflow;
   logic                  r_underflow;

   logic                  w_full;
   logic                  w_empty;
   logic                  w_wr_accept;
   logic                  w_rd_accept;
   logic [PW-1:0]         w_wr_ptr_nxt;
   logic [PW-1:0]         w_rd_ptr_nxt;

   // Status flags decode straight from the registered count, so they share its timing.
   assign w_full      = (r_count == c_depth);
   assign w_empty     = (r_count == '0);
   assign w_wr_accept = wr_en && !w_full;
   assign w_rd_accept = rd_en && !w_empty;

   // Explicit wrap so non-power-of-two depths work.
   assign w_wr_ptr_nxt = (r_wr_ptr == c_ptr_last) ? '0 : r_wr_ptr + c_ptr_one;
   assign w_rd_ptr_nxt = (r_rd_ptr == c_ptr_last) ? '0 : r_rd_ptr + c_ptr_one;

   // Storage array: written on accepted writes only, never cleared by reset.
   always_ff @(posedge clk) begin
      if (rst_n && w_wr_accept) begin
         r_mem[r_wr_ptr] <= data_in;
      end
   end

   // Pointers and occupancy; simultaneous accepted read and write leave count unchanged.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_wr_accept) begin
            r_wr_ptr <= w_wr_ptr_nxt;
         end
         if (w_rd_accept) begin
            r_rd_ptr <= w_rd_ptr_nxt;
         end
         case ({w_wr_accept, w_rd_accept})
            2'b10:   r_count <= r_count + c_cnt_one;
            2'b01:   r_count <= r_count - c_cnt_one;
            default: r_count <= r_count;
         endcase
      end
   end

   // Handshake pulses reflect only the attempt made at the current edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ack    <= 1'b0;
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else begin
         r_wr_ack    <= w_wr_accept;
         r_overflow  <= wr_en && w_full;
         r_underflow <= rd_en && w_empty;
      end
   end

`ifdef FIFO_FWFT_EN
   // Head of queue is presented combinationally; zero while nothing is stored.
   assign data_out = w_empty ? '0 : r_mem[r_rd_ptr];
`else
   logic [FIFO_WIDTH-1:0] r_data_out;

   // Read data loads on the accepting edge and holds through idle or rejected reads.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_data_out <= '0;
      end else if (w_rd_accept) begin
         r_data_out <= r_mem[r_rd_ptr];
      end
   end

   assign data_out = r_data_out;
`endif

   assign wr_ack      = r_wr_ack;
   assign overflow    = r_overflow;
   assign underflow   = r_underflow;
   assign full        = w_full;
   assign empty       = w_empty;
   assign almostfull  = (r_count >= c_af_th);
   assign almostempty = (r_count <= c_ae_th);
   assign count       = r_count;

endmodule
`default_nettype wire

// File: tb/tb_fifo_param_sync.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_fifo_param_sync                                         |
// | Description : Directed self-checking bench for fifo_param_sync          |
// |               (16 x 8, AF_TH=6, AE_TH=2). Honours FIFO_FWFT_EN.          |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_fifo_param_sync;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] data_in = '0;
   logic        wr_en = 1'b0;
   logic        rd_en = 1'b0;
   logic [15:0] data_out;
   logic        wr_ack;
   logic        overflow;
   logic        underflow;
   logic        full;
   logic        empty;
   logic        almostfull;
   logic        almostempty;
   logic [3:0]  count;

   int n_total = 0;
   int n_pass  = 0;

   fifo_param_sync #(
      .FIFO_WIDTH(16),
      .FIFO_DEPTH(8),
      .AF_TH     (6),
      .AE_TH     (2)
   ) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .data_in    (data_in),
      .wr_en      (wr_en),
      .rd_en      (rd_en),
      .data_out   (data_out),
      .wr_ack     (wr_ack),
      .overflow   (overflow),
      .underflow  (underflow),
      .full       (full),
      .empty      (empty),
      .almostfull (almostfull),
      .almostempty(almostempty),
      .count      (count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      if (obs === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // One clock with the given requests; returns 1 time unit after the edge.
   task automatic cyc(input logic w, input logic r, input logic [15:0] d);
      wr_en   = w;
      rd_en   = r;
      data_in = d;
      @(posedge clk);
      #1;
      wr_en = 1'b0;
      rd_en = 1'b0;
   endtask

   // Read cycle (optionally with a write) checking the popped word in either read mode.
   task automatic pop_cycle(input logic w, input logic [15:0] d, input logic [15:0] exp,
                            input string tag);
`ifdef FIFO_FWFT_EN
      check(tag, 32'(data_out), 32'(exp));
      cyc(w, 1'b1, d);
`else
      cyc(w, 1'b1, d);
      check(tag, 32'(data_out), 32'(exp));
`endif
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check("rst_count", 32'(count), 32'd0);
      check("rst_empty", 32'(empty), 32'd1);
      check("rst_ae", 32'(almostempty), 32'd1);
      check("rst_full", 32'(full), 32'd0);
      check("rst_af", 32'(almostfull), 32'd0);
      check("rst_dout", 32'(data_out), 32'd0);
      check("rst_pulses", 32'({wr_ack, overflow, underflow}), 32'd0);
      rst_n = 1'b1;

      // Read on empty: one-cycle underflow, nothing else moves
      cyc(1'b0, 1'b1, 16'h0000);
      check("t3_uflow", 32'(underflow), 32'd1);
      check("t3_count", 32'(count), 32'd0);
      check("t3_dout", 32'(data_out), 32'd0);
      cyc(1'b0, 1'b0, 16'h0000);
      check("t3_uflow_clr", 32'(underflow), 32'd0);

      // Single write then read
      cyc(1'b1, 1'b0, 16'hA5A5);
      check("t1_wr_ack", 32'(wr_ack), 32'd1);
      check("t1_count1", 32'(count), 32'd1);
      check("t1_empty0", 32'(empty), 32'd0);
      pop_cycle(1'b0, 16'h0000, 16'hA5A5, "t1_data");
      check("t1_ack_clr", 32'(wr_ack), 32'd0);
      check("t1_empty1", 32'(empty), 32'd1);
      check("t1_count0", 32'(count), 32'd0);

      // Fill 1..8 with threshold checks along the way
      for (int i = 1; i <= 8; i++) begin
         cyc(1'b1, 1'b0, 16'(i));
         check($sformatf("t2_count%0d", i), 32'(count), 32'(i));
         if (i == 2) check("t5_ae_at2", 32'(almostempty), 32'd1);
         if (i == 3) check("t5_ae_at3", 32'(almostempty), 32'd0);
         if (i == 5) check("t5_af_at5", 32'(almostfull), 32'd0);
         if (i == 6) check("t5_af_at6", 32'(almostfull), 32'd1);
      end
      check("t2_full", 32'(full), 32'd1);
      check("t2_wr_ack8", 32'(wr_ack), 32'd1);
      cyc(1'b1, 1'b0, 16'h0009);
      check("t2_oflow", 32'(overflow), 32'd1);
      check("t2_ack9", 32'(wr_ack), 32'd0);
      check("t2_count9", 32'(count), 32'd8);

      // Simultaneous read/write while full: read only
      pop_cycle(1'b1, 16'h0099, 16'h0001, "t4_full_rw_data");
      check("t4_full_rw_cnt", 32'(count), 32'd7);
      check("t4_full_rw_oflow", 32'(overflow), 32'd1);
      check("t4_full_rw_ack", 32'(wr_ack), 32'd0);
      check("t4_full_clr", 32'(full), 32'd0);
      for (int i = 2; i <= 4; i++) begin
         pop_cycle(1'b0, 16'h0000, 16'(i), $sformatf("t2_pop%0d", i));
      end
      check("t4_oflow_clr", 32'(overflow), 32'd0);
      check("t4_count4", 32'(count), 32'd4);

      // 20 simultaneous ops at count 4, wrapping both pointers
      for (int k = 0; k < 20; k++) begin
         pop_cycle(1'b1, 16'(100 + k), 16'((k < 4) ? (5 + k) : (96 + k)),
                   $sformatf("t4_rw%0d", k));
         check($sformatf("t4_rw_cnt%0d", k), 32'(count), 32'd4);
         check($sformatf("t4_rw_ack%0d", k), 32'(wr_ack), 32'd1);
      end
      for (int k = 16; k < 20; k++) begin
         pop_cycle(1'b0, 16'h0000, 16'(100 + k), $sformatf("t4_drain%0d", k));
      end
      check("t4_empty", 32'(empty), 32'd1);
      check("t4_count0", 32'(count), 32'd0);

      // Asynchronous reset mid-burst at count 5
      for (int i = 0; i < 5; i++) begin
         cyc(1'b1, 1'b0, 16'(16'h0200 + i));
      end
      check("t6_count5", 32'(count), 32'd5);
      check("t6_ack_pre", 32'(wr_ack), 32'd1);
      wr_en   = 1'b1;
      data_in = 16'h0300;
      #2;
      rst_n = 1'b0;
      #1;
      check("t6_count", 32'(count), 32'd0);
      check("t6_empty", 32'(empty), 32'd1);
      check("t6_ae", 32'(almostempty), 32'd1);
      check("t6_flags", 32'({full, almostfull}), 32'd0);
      check("t6_pulses", 32'({wr_ack, overflow, underflow}), 32'd0);
      check("t6_dout", 32'(data_out), 32'd0);
      @(posedge clk);
      #1;
      wr_en = 1'b0;
      rst_n = 1'b1;
      check("t6_count_held", 32'(count), 32'd0);
      cyc(1'b1, 1'b0, 16'h1234);
      check("t6_count1", 32'(count), 32'd1);
      pop_cycle(1'b0, 16'h0000, 16'h1234, "t6_data");
      check("t6_empty_end", 32'(empty), 32'd1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
